imem_fetch_responder: RTL



---
 rtl/imem_fetch_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: serves halfword-aligned fetches from a word RAM, joining straddling 32-bit instructions from two reads.
// Optional IMEM_LAST_WORD_BUF_EN keeps the last word read in a one-entry buffer so a hit skips the first RAM read.
module imem_fetch_responder #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] NOOP_INSTR  = 32'h00000013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic                           flush,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_instr,
    output logic [ADDR_WIDTH-1:0]          rsp_addr,
    output logic                           rsp_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_W = (ADDR_WIDTH-2)'(DEPTH_WORDS);
    localparam logic [IW:0]           DEPTH_I = (IW+1)'(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD0  = 2'd1;
    localparam logic [1:0] S_RD1  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_reg;
    logic        rd_en;
    logic [IW-1:0] rd_idx;

    logic [1:0]            state_reg, state_next;
    logic [IW-1:0]         w_reg, w_next;
    logic                  half_reg, half_next;
    logic [15:0]           lo_reg, lo_next;
    logic [31:0]           instr_reg, instr_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  err_reg, err_next;

    logic        accept;
    logic        req_oor;
    logic [IW:0] wp1;

    assign req_ready = !rst && (state_reg == S_IDLE) && !load_en && !flush;
    assign accept    = req_valid && req_ready;
    assign req_oor   = req_addr[ADDR_WIDTH-1:2] >= DEPTH_W;
    // One extra bit so the word after the last one is seen as out of range rather than wrapping to 0.
    assign wp1       = {1'b0, w_reg} + (IW+1)'(1);

    assign rsp_valid = (state_reg == S_RESP);
    assign rsp_instr = instr_reg;
    assign rsp_addr  = addr_reg;
    assign rsp_err   = err_reg;

    // Single RAM port: loader writes win; the FSM never requests a read in a load cycle.
    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (rd_en)
            rd_data_reg <= mem[rd_idx];
    end

`ifdef IMEM_LAST_WORD_BUF_EN
    // rd_data_reg only changes on a read, so it always holds the buffered word itself.
    logic          buf_valid_reg;
    logic [IW-1:0] buf_idx_reg;
    logic          buf_hit;
    logic [IW:0]   req_wp1;

    assign buf_hit = buf_valid_reg && (buf_idx_reg == req_addr[IW+1:2]);
    assign req_wp1 = {1'b0, req_addr[IW+1:2]} + (IW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_idx_reg   <= '0;
        end else if (load_en && (load_addr == buf_idx_reg)) begin
            buf_valid_reg <= 1'b0;
        end else if (rd_en) begin
            buf_valid_reg <= 1'b1;
            buf_idx_reg   <= rd_idx;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        half_next  = half_reg;
        lo_next    = lo_reg;
        instr_next = instr_reg;
        addr_next  = addr_reg;
        err_next   = err_reg;
        rd_en      = 1'b0;
        rd_idx     = w_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    w_next    = req_addr[IW+1:2];
                    half_next = req_addr[1];
                    addr_next = req_addr;
                    err_next  = 1'b0;
                    if (req_addr[0] || req_oor) begin
                        err_next   = 1'b1;
                        instr_next = NOOP_INSTR;
                        state_next = S_RESP;
                    end
`ifdef IMEM_LAST_WORD_BUF_EN
                    else if (buf_hit) begin
                        if (!req_addr[1]) begin
                            instr_next = rd_data_reg;
                            state_next = S_RESP;
                        end else if (rd_data_reg[17:16] != 2'b11) begin
                            instr_next = {16'h0000, rd_data_reg[31:16]};
                            state_next = S_RESP;
                        end else if (req_wp1 >= DEPTH_I) begin
                            err_next   = 1'b1;
                            instr_next = NOOP_INSTR;
                            state_next = S_RESP;
                        end else begin
                            lo_next    = rd_data_reg[31:16];
                            rd_en      = 1'b1;
                            rd_idx     = req_wp1[IW-1:0];
                            state_next = S_RD1;
                        end
                    end
`endif
                    else begin
                        rd_en      = 1'b1;
                        rd_idx     = req_addr[IW+1:2];
                        state_next = S_RD0;
                    end
                end
            end
            S_RD0: begin
                if (!half_reg) begin
                    instr_next = rd_data_reg;
                    state_next = S_RESP;
                end else if (rd_data_reg[17:16] != 2'b11) begin
                    instr_next = {16'h0000, rd_data_reg[31:16]};
                    state_next = S_RESP;
                end else begin
                    lo_next = rd_data_reg[31:16];
                    if (wp1 >= DEPTH_I) begin
                        err_next   = 1'b1;
                        instr_next = NOOP_INSTR;
                        state_next = S_RESP;
                    end else if (!load_en) begin
                        rd_en      = 1'b1;
                        rd_idx     = wp1[IW-1:0];
                        state_next = S_RD1;
                    end
                end
            end
            S_RD1: begin
                instr_next = {rd_data_reg[15:0], lo_reg};
                state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
            rd_en      = 1'b0;
            instr_next = instr_reg;
            addr_next  = addr_reg;
            err_next   = err_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            w_reg     <= '0;
            half_reg  <= 1'b0;
            lo_reg    <= '0;
            instr_reg <= NOOP_INSTR;
            addr_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
            half_reg  <= half_next;
            lo_reg    <= lo_next;
            instr_reg <= instr_next;
            addr_reg  <= addr_next;
            err_reg   <= err_next;
        end
    end
endmodule
